// File: rtl/serial_pattern_tx_pkg.sv
// Shared state encodings for the serial pattern transmitter and the matching
// two-consecutive-1s detector, so both sides agree on the encodings.
package serial_pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } txState_e;

    // Detector encodings: A = last bit was 0, B = last bit was 1.
    localparam logic DET_A = 1'b0;
    localparam logic DET_B = 1'b1;

endpackage

// File: rtl/serial_pattern_tx_pair_hit_counter.sv
// Counts adjacent 1-1 pairs in a stream of bits. The bit before the first
// valid bit after a clear is taken as 0.
module pair_hit_counter #(
    parameter int CW = 3
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clear_i,
    input  logic          bitValid_i,
    input  logic          bit_i,
    output logic [CW-1:0] countNext_o
);
    logic          prevBit_q;
    logic [CW-1:0] count_q;

    // Next count includes the bit currently presented, so the top can latch it on the last bit.
    always_comb begin
        countNext_o = count_q;
        if (bitValid_i) begin
            countNext_o = count_q + CW'(prevBit_q & bit_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            prevBit_q <= 1'b0;
            count_q   <= '0;
        end else if (bitValid_i) begin
            prevBit_q <= bit_i;
            count_q   <= countNext_o;
        end
    end

endmodule

// File: rtl/serial_pattern_tx.sv
// Accepts a parallel word over valid/ready and shifts it out MSB-first on w,
// reporting the number of 1-1 pairs the detector will flag for that word.
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 2,
    localparam int CW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             w_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CW-1:0]    hits_o
);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    txState_e         state_q;
    logic [WIDTH-1:0] shiftReg_q;
    logic [CW-1:0]    bitCnt_q;
    logic [GW-1:0]    gapCnt_q;
    logic             w_q;
    logic             done_q;
    logic [CW-1:0]    hits_q;
    logic [CW-1:0]    pairCount_d;
    logic             accept;
    logic             shifting;

    assign accept   = (state_q == ST_IDLE) && load_i;
    assign shifting = (state_q == ST_SHIFT);

    pair_hit_counter #(.CW(CW)) u_pairHitCounter (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clear_i     (accept),
        .bitValid_i  (shifting),
        .bit_i       (w_q),
        .countNext_o (pairCount_d)
    );

    // w is loaded with the MSB on acceptance so bit k appears in cycle k after the accept edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            shiftReg_q <= '0;
            bitCnt_q   <= '0;
            gapCnt_q   <= '0;
            w_q        <= 1'b0;
            done_q     <= 1'b0;
            hits_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_i) begin
                        state_q    <= ST_SHIFT;
                        shiftReg_q <= data_i;
                        bitCnt_q   <= '0;
                        w_q        <= data_i[WIDTH-1];
                    end
                end
                ST_SHIFT: begin
                    if (bitCnt_q == BIT_LAST) begin
                        w_q      <= 1'b0;
                        done_q   <= 1'b1;
                        hits_q   <= pairCount_d;
                        gapCnt_q <= '0;
                        state_q  <= (GAP > 0) ? ST_GAP : ST_IDLE;
                    end else begin
                        bitCnt_q   <= bitCnt_q + 1'b1;
                        shiftReg_q <= shiftReg_q << 1;
                        w_q        <= shiftReg_q[WIDTH-2];
                    end
                end
                ST_GAP: begin
                    if (gapCnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gapCnt_q <= gapCnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready_o = (state_q == ST_IDLE);
    assign busy_o  = (state_q == ST_SHIFT) || (state_q == ST_GAP);
    assign w_o     = w_q;
    assign done_o  = done_q;
    assign hits_o  = hits_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: one instance with GAP=2, one with GAP=0,
// plus a behavioural two-1s detector fed from the GAP=2 serial line.
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       loadA, loadB;
    logic [7:0] dataA, dataB;
    logic       readyA, wA, busyA, doneA;
    logic       readyB, wB, busyB, doneB;
    logic [2:0] hitsA, hitsB;

    int checks   = 0;
    int failures = 0;

    int detPrev  = 0;
    int zCount   = 0;
    int zStart   = 0;

    typedef struct {
        logic [7:0] data;
        int         hits;
    } vector_t;

    vector_t vectors[8];

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(8), .GAP(2)) dutA (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (loadA),
        .data_i  (dataA),
        .ready_o (readyA),
        .w_o     (wA),
        .busy_o  (busyA),
        .done_o  (doneA),
        .hits_o  (hitsA)
    );

    serial_pattern_tx #(.WIDTH(8), .GAP(0)) dutB (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (loadB),
        .data_i  (dataB),
        .ready_o (readyB),
        .w_o     (wB),
        .busy_o  (busyB),
        .done_o  (doneB),
        .hits_o  (hitsB)
    );

    // Mealy detector model: z fires when the previous and current w are both 1.
    always @(posedge clk) begin
        if (reset) begin
            detPrev <= 0;
        end else begin
            if (detPrev == 1 && wA == 1'b1) zCount <= zCount + 1;
            detPrev <= (wA == 1'b1) ? 1 : 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic waitReadyA();
        int n = 0;
        while (readyA !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (readyA !== 1'b1) checkOutput("readyA_timeout", {31'd0, readyA}, 32'd1);
    endtask

    // Sends one word on dutA; pulses a rejected Load of 8'h55 in cycle pulseAt (-1 for none).
    task automatic applyStimulus(input logic [7:0] d, input int expHits, input int pulseAt);
        waitReadyA();
        loadA = 1'b1;
        dataA = d;
        tick();
        zStart = zCount;
        loadA  = 1'b0;
        dataA  = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            checkOutput("w_bit", {31'd0, wA}, {31'd0, d[7-k]});
            checkOutput("busy_shift", {31'd0, busyA}, 32'd1);
            if (k == pulseAt) begin
                loadA = 1'b1;
                dataA = 8'h55;
            end else begin
                loadA = 1'b0;
            end
            tick();
        end
        loadA = 1'b0;
        checkOutput("done_pulse", {31'd0, doneA}, 32'd1);
        checkOutput("w_after_word", {31'd0, wA}, 32'd0);
        checkOutput("hits", {29'd0, hitsA}, 32'(expHits));
        checkOutput("detector_z", 32'(zCount - zStart), 32'(expHits));
        checkOutput("ready_gap1", {31'd0, readyA}, 32'd0);
        tick();
        checkOutput("done_cleared", {31'd0, doneA}, 32'd0);
        checkOutput("ready_gap2", {31'd0, readyA}, 32'd0);
        checkOutput("hits_hold", {29'd0, hitsA}, 32'(expHits));
        tick();
        checkOutput("ready_back", {31'd0, readyA}, 32'd1);
        checkOutput("busy_idle", {31'd0, busyA}, 32'd0);
        checkOutput("w_idle", {31'd0, wA}, 32'd0);
    endtask

    initial begin
        vectors[0] = '{8'b0110_1110, 3};
        vectors[1] = '{8'hFF, 7};
        vectors[2] = '{8'hAA, 0};
        vectors[3] = '{8'h00, 0};
        vectors[4] = '{8'hC3, 2};
        vectors[5] = '{8'h7F, 6};
        vectors[6] = '{8'hE7, 4};
        vectors[7] = '{8'h81, 0};

        reset = 1'b1;
        loadA = 1'b0;
        loadB = 1'b0;
        dataA = 8'h00;
        dataB = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_ready", {31'd0, readyA}, 32'd1);
        checkOutput("reset_w", {31'd0, wA}, 32'd0);
        checkOutput("reset_done", {31'd0, doneA}, 32'd0);
        checkOutput("reset_hits", {29'd0, hitsA}, 32'd0);
        checkOutput("reset_busy", {31'd0, busyA}, 32'd0);

        foreach (vectors[i]) begin
            applyStimulus(vectors[i].data, vectors[i].hits, -1);
        end

        // A Load while busy must be dropped without disturbing the word in flight.
        applyStimulus(8'hFF, 7, 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("ignored_load_w", {31'd0, wA}, 32'd0);
            checkOutput("ignored_load_busy", {31'd0, busyA}, 32'd0);
            tick();
        end

        // Reset during bit 3 aborts the word.
        waitReadyA();
        loadA = 1'b1;
        dataA = 8'hFF;
        tick();
        loadA = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_w", {31'd0, wA}, 32'd0);
        checkOutput("abort_ready", {31'd0, readyA}, 32'd1);
        checkOutput("abort_hits", {29'd0, hitsA}, 32'd0);
        checkOutput("abort_done", {31'd0, doneA}, 32'd0);
        for (int i = 0; i < 9; i++) begin
            tick();
            checkOutput("abort_no_done", {31'd0, doneA}, 32'd0);
            checkOutput("abort_w_quiet", {31'd0, wA}, 32'd0);
        end
        applyStimulus(8'hE7, 4, -1);

        // Reset and Load on the same edge: reset wins.
        reset = 1'b1;
        loadA = 1'b1;
        dataA = 8'hFF;
        tick();
        reset = 1'b0;
        loadA = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rst_load_w", {31'd0, wA}, 32'd0);
            checkOutput("rst_load_busy", {31'd0, busyA}, 32'd0);
            checkOutput("rst_load_ready", {31'd0, readyA}, 32'd1);
            tick();
        end

        // GAP=0 with Load held high: back-to-back words every 9 cycles.
        checkOutput("b_ready_start", {31'd0, readyB}, 32'd1);
        loadB = 1'b1;
        dataB = 8'hC3;
        tick();
        for (int c = 0; c < 27; c++) begin
            logic [7:0] pattern;
            pattern = 8'hC3;
            if (c % 9 == 8) begin
                checkOutput("b_w_separator", {31'd0, wB}, 32'd0);
                checkOutput("b_done", {31'd0, doneB}, 32'd1);
                checkOutput("b_hits", {29'd0, hitsB}, 32'd2);
                checkOutput("b_ready", {31'd0, readyB}, 32'd1);
            end else begin
                checkOutput("b_w_bit", {31'd0, wB}, {31'd0, pattern[7 - (c % 9)]});
                checkOutput("b_no_done", {31'd0, doneB}, 32'd0);
            end
            tick();
        end
        loadB = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
